// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: state encoding and
// elaboration-time helpers that convert milliseconds to clock cycles.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } kc_state_e;

  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Counter width that never collapses to zero bits for tiny counts.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Event/level bundle produced by key_conditioner and consumed downstream
// (e.g. the HEX rotator's run/stop toggle and pattern reset).
interface key_conditioner_if;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (output key_level, press_pulse, release_pulse, long_pulse);
  modport slave  (input  key_level, press_pulse, release_pulse, long_pulse);
endinterface

// File: rtl/key_conditioner_sync2.sv
// Generic 2-FF synchroniser with a configurable reset value; also used for
// slide-switch inputs.
module sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s0 <= d;
      q  <= s0;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Debounces an active-low board key into a clean level plus press, release
// and long-press pulses. Define KEY_REPEAT_EN to add auto-repeat press pulses.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              KEY_n,
  key_conditioner_if.master kif
);

  localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
  localparam int REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);
  localparam int DB_W     = cnt_w(DB_CYC);
  localparam int HOLD_W   = cnt_w(LONG_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  if (LONG_CYC <= DB_CYC || REP_CYC < 1) begin : g_bad_cfg
    $error("key_conditioner: need LONG_CYC > DB_CYC and REP_CYC >= 1");
  end

  logic              s1;
  kc_state_e         state;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              level_q, press_q, rel_q, long_q;
  logic              holding;

  sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (CLOCK_50),
    .rst (reset),
    .d   (KEY_n),
    .q   (s1)
  );

  // The long timer keeps running through release bounces so a glitch
  // does not restart it; saturation makes long_pulse fire once per press.
  assign holding = (state == PRESSED) || (state == RELEASE_CHK);

`ifdef KEY_REPEAT_EN
  localparam int                REP_W    = cnt_w(REP_CYC);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REP_CYC - 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= RELEASED;
      db_cnt   <= '0;
      hold_cnt <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt  <= '0;
`endif
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt <= '0;
`endif
      if (holding && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) long_q <= 1'b1;
      end

      unique case (state)
        RELEASED: begin
          if (!s1) begin
            state  <= PRESS_CHK;
            db_cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (s1) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state    <= PRESSED;
            press_q  <= 1'b1;
            level_q  <= 1'b1;
            hold_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (s1) begin
            state  <= RELEASE_CHK;
            db_cnt <= '0;
          end
`ifdef KEY_REPEAT_EN
          // Repeat only once the long threshold has been passed.
          else if (hold_cnt == HOLD_MAX) begin
            if (rep_cnt == REP_LAST) begin
              press_q <= 1'b1;
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
`endif
        end
        RELEASE_CHK: begin
          if (!s1) begin
            state <= PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state   <= RELEASED;
            rel_q   <= 1'b1;
            level_q <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

  assign kif.key_level     = level_q;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = rel_q;
  assign kif.long_pulse    = long_q;

endmodule
